registerpairfile: RTL and testbench
===================================

# registerpairfile

Parametrised successor to the core's byte register file. It adds 16-bit register-pair read/write, a single-cycle pair increment/decrement unit with a wrap indication, and a driven (non-tristate) read path. It sits between the decoder/ALU datapath and the address unit of the core. It supplies the register pairs (BC/DE/HL-style) for addressing and holds the dedicated flag register.

## Interface
- DATASIZE, 8, width of one register
- ADDRSIZE, 3, byte address width; REGCOUNT = 2**ADDRSIZE; must be >= 2
- REG_FLAG, 6, index of the flag register; must be < REGCOUNT
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- wrenb  in  1  byte write enable
- waddr  in  ADDRSIZE  byte write address
- wdata  in  DATASIZE  byte write data
- flenb  in  1  flag register write enable
- ifdat  in  DATASIZE  flag write data
- pwenb  in  1  pair write enable
- pwadd  in  ADDRSIZE-1  pair write address
- pwdat  in  2*DATASIZE  pair write data, {high,low}
- pienb  in  1  pair increment/decrement enable
- pidec  in  1  1 = decrement, 0 = increment
- piadd  in  ADDRSIZE-1  pair inc/dec address
- r1enb, r2enb  in  1  byte read port enables
- r1add, r2add  in  ADDRSIZE  byte read addresses
- r1dat, r2dat  out  DATASIZE  byte read data
- pradd  in  ADDRSIZE-1  pair read address
- prdat  out  2*DATASIZE  pair read data, {high,low}
- ofdat  out  DATASIZE  flag register contents
- pwrap  out  1  registered wrap pulse from inc/dec

## Operation
- Pair p = {R[2p] (high), R[2p+1] (low)}; REGCOUNT/2 pairs.
- R[REG_FLAG] is written only by flenb/ifdat; byte and pair writes skip that byte.
  - A pair write to the pair containing R[REG_FLAG] updates only the other byte.
  - Inc/dec of the pair containing R[REG_FLAG] is ignored entirely: no write, no pwrap.
- Inc/dec: pair <= pair ± 1 modulo 2**(2*DATASIZE).
- Wrap cases: 0xFFFF inc -> 0x0000, and 0x0000 dec -> 0xFFFF. Each sets pwrap on the next cycle.
- Simultaneous writes to distinct bytes all apply.
- Per-byte priority on conflict: pair write > pair inc/dec > byte write.
  - Pair write and inc/dec on the same pair: the write wins, and pwrap stays 0.
  - A byte write into a pair under inc/dec is discarded.
- Byte reads are combinational. r1dat/r2dat = R[addr] when the enable is high, else all-zeros; they are never high-Z.
- Both byte read ports may address the same register.
- prdat is always driven from pradd. ofdat is always R[REG_FLAG].

## Timing
- All register updates happen on the rising clk edge; write-to-read latency is 1 cycle (see Configuration).
- pwrap is high for exactly the one cycle after a wrapping inc/dec edge, and low otherwise. Back-to-back wraps give consecutive high cycles.
- Reset (rst low, asynchronous, any time including mid-operation): every register is 0 and pwrap is 0. Consequently ofdat = 0 and prdat = 0, and r1dat/r2dat are 0 regardless of enables.
- While rst is low, all write enables are ignored. Normal operation resumes on the first rising edge after rst goes high.

## Configuration
- REGFILE_BYPASS_EN defined:
  - r1dat, r2dat and prdat return the post-priority next value of any byte being written in the current cycle (byte write, pair write, inc/dec result).
  - The effective write-to-read latency becomes 0.
  - ofdat and pwrap are unaffected.
- Undefined: reads return stored contents only; new data is visible the cycle after the write edge.

## Test plan
- Reset then byte writes: rst low, then write R0=0x12 and R1=0x34 -> r1add=0 gives 0x12; pradd=0 gives prdat=0x1234. Pulse rst low mid-run -> all outputs 0 immediately.
- Flag isolation: wrenb with waddr=6, wdata=0xFF -> ofdat stays 0. flenb with ifdat=0xA5 -> ofdat=0xA5. pwenb to pair 3 with 0xBEEF -> R6=0xA5, R7=0xEF.
- Inc/dec wrap: pair 2 = 0xFFFF, pienb inc -> prdat=0x0000 and pwrap=1 for one cycle. Then dec -> 0xFFFF and pwrap=1. Then dec -> 0xFFFE and pwrap=0.
- Priority: pair 1 = 0x00FF, same cycle pwenb 0x1111 and pienb inc -> 0x1111, pwrap=0. Next cycle pienb inc with wrenb waddr=3, wdata=0x55 -> 0x1112.
- Read enables: r1enb=0 -> r1dat=0. r1add=r2add=2 with both enabled -> both equal R2.
- Bypass: write R4=0x77 with r1add=4. With REGFILE_BYPASS_EN, r1dat=0x77 in the same cycle; without it, the old value shows until the next cycle.

Source files
------------

// File: rtl/registerpairfile.sv
// registerpairfile: byte register file with 16-bit register-pair read/write,
// a single-cycle pair increment/decrement unit with a registered wrap pulse,
// and a dedicated flag register that only flenb/ifdat can modify.
// Optional build macro: REGFILE_BYPASS_EN forwards the post-priority next value
// of any byte being written to r1dat/r2dat/prdat in the same cycle.
module registerpairfile #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 3,
   parameter int REG_FLAG = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wrenb,
   input  logic [ADDRSIZE-1:0]     waddr,
   input  logic [DATASIZE-1:0]     wdata,
   input  logic                    flenb,
   input  logic [DATASIZE-1:0]     ifdat,
   input  logic                    pwenb,
   input  logic [ADDRSIZE-2:0]     pwadd,
   input  logic [2*DATASIZE-1:0]   pwdat,
   input  logic                    pienb,
   input  logic                    pidec,
   input  logic [ADDRSIZE-2:0]     piadd,
   input  logic                    r1enb,
   input  logic [ADDRSIZE-1:0]     r1add,
   output logic [DATASIZE-1:0]     r1dat,
   input  logic                    r2enb,
   input  logic [ADDRSIZE-1:0]     r2add,
   output logic [DATASIZE-1:0]     r2dat,
   input  logic [ADDRSIZE-2:0]     pradd,
   output logic [2*DATASIZE-1:0]   prdat,
   output logic [DATASIZE-1:0]     ofdat,
   output logic                    pwrap
);

   localparam int REGCOUNT  = 2**ADDRSIZE;
   localparam int PAIRBITS  = ADDRSIZE - 1;
   localparam int PAIRWIDTH = 2 * DATASIZE;
   localparam logic [PAIRBITS-1:0]  FLAG_PAIR = PAIRBITS'(REG_FLAG / 2);
   localparam logic [PAIRWIDTH-1:0] PAIR_ONE  = PAIRWIDTH'(1);
   localparam logic [PAIRWIDTH-1:0] PAIR_MAX  = '1;

   logic [DATASIZE-1:0]  regs_reg  [REGCOUNT];
   logic [DATASIZE-1:0]  regs_next [REGCOUNT];
   logic [DATASIZE-1:0]  rd_view   [REGCOUNT];
   logic                 pwrap_reg;
   logic                 pwrap_next;
   logic [PAIRWIDTH-1:0] pi_cur;
   logic [PAIRWIDTH-1:0] pi_res;
   logic                 pi_ok;
   logic                 pi_wrap;

   // Inc/dec unit: operates on the addressed pair; the pair holding the flag
   // register is never touched by it, so such a request is dropped entirely.
   assign pi_cur  = {regs_reg[{piadd, 1'b0}], regs_reg[{piadd, 1'b1}]};
   assign pi_ok   = pienb && (piadd != FLAG_PAIR);
   assign pi_res  = pidec ? (pi_cur - PAIR_ONE) : (pi_cur + PAIR_ONE);
   assign pi_wrap = pidec ? (pi_cur == '0) : (pi_cur == PAIR_MAX);

   // A pair write to the same pair overrides the inc/dec, so no wrap is reported then.
   assign pwrap_next = pi_ok && pi_wrap && !(pwenb && (pwadd == piadd));

   genvar gi;
   generate
      for (gi = 0; gi < REGCOUNT; gi++) begin : g_byte
         localparam logic [ADDRSIZE-1:0] BYTE_ADDR = ADDRSIZE'(gi);
         localparam logic [PAIRBITS-1:0] BYTE_PAIR = PAIRBITS'(gi / 2);
         localparam bit                  IS_HIGH   = ((gi % 2) == 0);

         if (gi == REG_FLAG) begin : g_flag
            // Flag byte: only the dedicated flag port can write it.
            assign regs_next[gi] = flenb ? ifdat : regs_reg[gi];
         end else begin : g_data
            logic [DATASIZE-1:0] pw_byte;
            logic [DATASIZE-1:0] pi_byte;

            // Even index is the high byte of its pair, odd index the low byte.
            assign pw_byte = IS_HIGH ? pwdat[PAIRWIDTH-1:DATASIZE] : pwdat[DATASIZE-1:0];
            assign pi_byte = IS_HIGH ? pi_res[PAIRWIDTH-1:DATASIZE] : pi_res[DATASIZE-1:0];

            // Per-byte priority: pair write, then inc/dec, then byte write.
            assign regs_next[gi] = (pwenb && (pwadd == BYTE_PAIR)) ? pw_byte :
                                   (pi_ok && (piadd == BYTE_PAIR)) ? pi_byte :
                                   (wrenb && (waddr == BYTE_ADDR)) ? wdata   :
                                   regs_reg[gi];
         end

         // Byte storage, cleared asynchronously while rst is low.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               regs_reg[gi] <= '0;
            end else begin
               regs_reg[gi] <= regs_next[gi];
            end
         end

`ifdef REGFILE_BYPASS_EN
         // Forward the pending write; during reset the stored zero is shown instead.
         assign rd_view[gi] = rst ? regs_next[gi] : regs_reg[gi];
`else
         assign rd_view[gi] = regs_reg[gi];
`endif
      end
   endgenerate

   // Wrap pulse register: high for the single cycle after a wrapping inc/dec.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwrap_reg <= 1'b0;
      end else begin
         pwrap_reg <= pwrap_next;
      end
   end

   // Driven read paths: disabled byte ports return zero, never high-Z.
   assign r1dat = r1enb ? rd_view[r1add] : '0;
   assign r2dat = r2enb ? rd_view[r2add] : '0;
   assign prdat = {rd_view[{pradd, 1'b0}], rd_view[{pradd, 1'b1}]};
   assign ofdat = regs_reg[REG_FLAG];
   assign pwrap = pwrap_reg;

endmodule

// File: tb/tb_registerpairfile.sv
// tb_registerpairfile: scoreboard bench for registerpairfile (8-bit bytes,
// 8 registers, flag at index 6). Expectations come from a layered-overwrite
// model of the register file and are queued before the DUT is sampled.
`timescale 1ns/1ps
module tb_registerpairfile;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wrenb, flenb, pwenb, pienb, pidec, r1enb, r2enb;
   logic [2:0]  waddr, r1add, r2add;
   logic [1:0]  pwadd, piadd, pradd;
   logic [7:0]  wdata, ifdat, r1dat, r2dat, ofdat;
   logic [15:0] pwdat, prdat;
   logic        pwrap;

   always #5 clk = ~clk;

   registerpairfile #(.DATASIZE(8), .ADDRSIZE(3), .REG_FLAG(6)) dut (
      .clk(clk), .rst(rst),
      .wrenb(wrenb), .waddr(waddr), .wdata(wdata),
      .flenb(flenb), .ifdat(ifdat),
      .pwenb(pwenb), .pwadd(pwadd), .pwdat(pwdat),
      .pienb(pienb), .pidec(pidec), .piadd(piadd),
      .r1enb(r1enb), .r1add(r1add), .r1dat(r1dat),
      .r2enb(r2enb), .r2add(r2add), .r2dat(r2dat),
      .pradd(pradd), .prdat(prdat),
      .ofdat(ofdat), .pwrap(pwrap)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   string       tag_q[$];
   logic [15:0] val_q[$];
   logic [7:0]  mdl[8];
   logic [7:0]  nxt[8];
   logic        wrap_mdl;
   logic        wrap_n;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [15:0] dut_out(input string tag);
      if (tag == "r1") return {8'h00, r1dat};
      else if (tag == "r2") return {8'h00, r2dat};
      else if (tag == "pr") return prdat;
      else if (tag == "of") return {8'h00, ofdat};
      else return {15'h0000, pwrap};
   endfunction

   task automatic sb_push(input string tag, input logic [15:0] v);
      tag_q.push_back(tag);
      val_q.push_back(v);
   endtask

   task automatic sb_drain();
      string       t;
      logic [15:0] v;
      while (tag_q.size() > 0) begin
         t = tag_q.pop_front();
         v = val_q.pop_front();
         chk(t, dut_out(t), v);
      end
   endtask

   task automatic idle();
      wrenb = 0; waddr = 0; wdata = 0;
      flenb = 0; ifdat = 0;
      pwenb = 0; pwadd = 0; pwdat = 0;
      pienb = 0; pidec = 0; piadd = 0;
      r1enb = 0; r1add = 0; r2enb = 0; r2add = 0; pradd = 0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
      wrap_mdl = 1'b0;
   endtask

   // Apply operations lowest priority first so higher ones overwrite.
   task automatic model_next();
      logic [15:0] v;
      logic [15:0] r;
      int          p;
      for (int i = 0; i < 8; i++) nxt[i] = mdl[i];
      wrap_n = 1'b0;
      if (wrenb) nxt[waddr] = wdata;
      if (pienb && piadd != 2'd3) begin
         p = int'(piadd);
         v = {mdl[2*p], mdl[2*p+1]};
         r = pidec ? v - 16'd1 : v + 16'd1;
         nxt[2*p]   = r[15:8];
         nxt[2*p+1] = r[7:0];
         wrap_n = pidec ? (v == 16'h0000) : (v == 16'hFFFF);
      end
      if (pwenb) begin
         p = int'(pwadd);
         nxt[2*p]   = pwdat[15:8];
         nxt[2*p+1] = pwdat[7:0];
         if (pienb && pwadd == piadd) wrap_n = 1'b0;
      end
      nxt[6] = flenb ? ifdat : mdl[6];
   endtask

   function automatic logic [7:0] view(input int a);
`ifdef REGFILE_BYPASS_EN
      return nxt[a];
`else
      return mdl[a];
`endif
   endfunction

   // One transaction: inputs already driven; queue expectations, sample before the edge.
   task automatic cycle();
      #2;
      model_next();
      sb_push("r1", {8'h00, r1enb ? view(int'(r1add)) : 8'h00});
      sb_push("r2", {8'h00, r2enb ? view(int'(r2add)) : 8'h00});
      sb_push("pr", {view(2*int'(pradd)), view(2*int'(pradd)+1)});
      sb_push("of", {8'h00, mdl[6]});
      sb_push("wrap", {15'h0000, wrap_mdl});
      sb_drain();
      $display("cyc %0d wr=%b/%0d/%h pw=%b/%0d/%h pi=%b/%b/%0d fl=%b/%h r1=%h r2=%h pr=%h of=%h wrap=%b",
               cyc, wrenb, waddr, wdata, pwenb, pwadd, pwdat, pienb, pidec, piadd,
               flenb, ifdat, r1dat, r2dat, prdat, ofdat, pwrap);
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) mdl[i] = nxt[i];
      wrap_mdl = wrap_n;
      cyc++;
   endtask

   task automatic chk_zero();
      sb_push("r1", 16'h0000);
      sb_push("r2", 16'h0000);
      sb_push("pr", 16'h0000);
      sb_push("of", 16'h0000);
      sb_push("wrap", 16'h0000);
      sb_drain();
      $display("reset check at cycle %0d: r1=%h r2=%h pr=%h of=%h wrap=%b", cyc, r1dat, r2dat, prdat, ofdat, pwrap);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      model_clear();
      // Reset held with every write and read enable active: all outputs stay 0.
      rst = 0; r1enb = 1; r1add = 0; r2enb = 1; r2add = 1;
      wrenb = 1; waddr = 0; wdata = 8'h99; pwenb = 1; pwdat = 16'hABCD;
      flenb = 1; ifdat = 8'h5A;
      repeat (2) @(posedge clk);
      #1;
      chk_zero();
      idle();
      rst = 1;

      // Byte writes then byte and pair reads
      idle(); wrenb = 1; waddr = 0; wdata = 8'h12; r1enb = 1; r1add = 0; cycle();
      idle(); wrenb = 1; waddr = 1; wdata = 8'h34; r1enb = 1; r1add = 0; pradd = 0; cycle();
      idle(); r1enb = 1; r1add = 0; pradd = 0; cycle();

      // Flag isolation
      idle(); wrenb = 1; waddr = 6; wdata = 8'hFF; r1enb = 1; r1add = 6; cycle();
      idle(); r1enb = 1; r1add = 6; cycle();
      idle(); flenb = 1; ifdat = 8'hA5; cycle();
      idle(); pwenb = 1; pwadd = 3; pwdat = 16'hBEEF; pradd = 3; cycle();
      idle(); pradd = 3; r1enb = 1; r1add = 6; r2enb = 1; r2add = 7; cycle();

      // Inc/dec wrap in both directions
      idle(); pwenb = 1; pwadd = 2; pwdat = 16'hFFFF; pradd = 2; cycle();
      idle(); pienb = 1; piadd = 2; pradd = 2; cycle();
      idle(); pienb = 1; pidec = 1; piadd = 2; pradd = 2; cycle();
      idle(); pienb = 1; pidec = 1; piadd = 2; pradd = 2; cycle();
      idle(); pradd = 2; cycle();

      // Inc on the flag's pair is ignored: no write, no wrap
      idle(); flenb = 1; ifdat = 8'hFF; pwenb = 1; pwadd = 3; pwdat = 16'hFFFF; cycle();
      idle(); pienb = 1; piadd = 3; pradd = 3; cycle();
      idle(); pradd = 3; cycle();

      // Priority: pair write beats inc/dec, inc/dec beats byte write
      idle(); pwenb = 1; pwadd = 1; pwdat = 16'h00FF; cycle();
      idle(); pwenb = 1; pwadd = 1; pwdat = 16'h1111; pienb = 1; piadd = 1; pradd = 1; cycle();
      idle(); pienb = 1; piadd = 1; wrenb = 1; waddr = 3; wdata = 8'h55; pradd = 1; cycle();
      idle(); pradd = 1; cycle();
      // Pair write over a would-be wrapping inc: wrap suppressed
      idle(); pwenb = 1; pwadd = 1; pwdat = 16'hFFFF; cycle();
      idle(); pwenb = 1; pwadd = 1; pwdat = 16'h2222; pienb = 1; piadd = 1; pradd = 1; cycle();
      idle(); pradd = 1; cycle();

      // Simultaneous writes to distinct bytes all apply
      idle(); wrenb = 1; waddr = 0; wdata = 8'hC3; pwenb = 1; pwadd = 2; pwdat = 16'h0102;
      pienb = 1; pidec = 1; piadd = 1; flenb = 1; ifdat = 8'h3C; cycle();
      idle(); r1enb = 1; r1add = 0; r2enb = 1; r2add = 3; pradd = 2; cycle();

      // Read enables and both ports on one register
      idle(); r1enb = 0; r1add = 2; r2enb = 1; r2add = 2; cycle();
      idle(); r1enb = 1; r1add = 2; r2enb = 1; r2add = 2; cycle();

      // Same-cycle visibility of a byte write
      idle(); wrenb = 1; waddr = 4; wdata = 8'h77; r1enb = 1; r1add = 4; pradd = 2; cycle();
      idle(); r1enb = 1; r1add = 4; pradd = 2; cycle();

      // Random mix of all operations
      for (int k = 0; k < 40; k++) begin
         wrenb = 1'($urandom_range(0, 1)); waddr = 3'($urandom_range(0, 7)); wdata = 8'($urandom);
         flenb = ($urandom_range(0, 3) == 0); ifdat = 8'($urandom);
         pwenb = ($urandom_range(0, 2) == 0); pwadd = 2'($urandom_range(0, 3));
         pwdat = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         pienb = 1'($urandom_range(0, 1)); pidec = 1'($urandom_range(0, 1)); piadd = 2'($urandom_range(0, 3));
         r1enb = 1'($urandom_range(0, 1)); r1add = 3'($urandom_range(0, 7));
         r2enb = 1'($urandom_range(0, 1)); r2add = 3'($urandom_range(0, 7));
         pradd = 2'($urandom_range(0, 3));
         cycle();
      end

      // Mid-run asynchronous reset while pwrap is high and writes are active
      idle(); pwenb = 1; pwadd = 2; pwdat = 16'hFFFF; cycle();
      idle(); pienb = 1; piadd = 2; cycle();
      idle(); r1enb = 1; r1add = 4; r2enb = 1; r2add = 0; pradd = 2;
      wrenb = 1; waddr = 0; wdata = 8'hAA; flenb = 1; ifdat = 8'h11;
      #1;
      sb_push("wrap", {15'h0000, wrap_mdl});
      sb_drain();
      #1;
      rst = 0;
      #1;
      chk_zero();
      @(posedge clk);
      #1;
      chk_zero();
      rst = 1;
      model_clear();
      idle(); wrenb = 1; waddr = 5; wdata = 8'h5E; r1enb = 1; r1add = 5; cycle();
      idle(); r1enb = 1; r1add = 5; pradd = 2; cycle();
      idle(); cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
